// File: rtl/window_gen_5x5.sv
// 5x5 neighbourhood generator for a raster luma stream: four cascaded line memories feed a
// 5-column shift register, with index, validity and 2-cycle delay-matched sync outputs.
module window_gen_5x5 #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_WIDTH = 1920,
  parameter int unsigned X_W       = 11,
  parameter int unsigned Y_W       = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     y_i,
  input  logic                  dv_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [25*DATA_W-1:0]  win_o,
  output logic                  win_valid_o,
  output logic [X_W-1:0]        x_index_o,
  output logic [Y_W-1:0]        y_index_o,
  output logic                  dv_o,
  output logic                  hs_o,
  output logic                  vs_o
);

  localparam int unsigned AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [X_W-1:0] XMax = X_W'(MAX_WIDTH);
  localparam logic [Y_W-1:0] YMax = '1;

  logic                  hs_q, vs_q;
  logic                  hs_rise, vs_rise;
  logic [X_W-1:0]        x_cnt_q, x_cnt_d;
  logic [Y_W-1:0]        y_cnt_q, y_cnt_d;
  logic                  in_range, we;
  logic [AW-1:0]         addr;

  logic [DATA_W-1:0]     lm [4][MAX_WIDTH];
  logic [3:0][DATA_W-1:0] rd_q;
  logic [DATA_W-1:0]     s1_pix_q;
  logic                  s1_dv_q;
  logic [X_W-1:0]        s1_x_q;
  logic [Y_W-1:0]        s1_y_q;
  logic                  s2_dv_q;
  logic [X_W-1:0]        s2_x_q;
  logic [Y_W-1:0]        s2_y_q;
  logic [4:0][DATA_W-1:0] col;
  logic [24:0][DATA_W-1:0] win_q;
  logic [1:0]            hs_dly_q, vs_dly_q;

  assign hs_rise  = hs_i & ~hs_q;
  assign vs_rise  = vs_i & ~vs_q;
  assign in_range = (x_cnt_q < XMax);
  assign we       = dv_i & in_range;
  assign addr     = x_cnt_q[AW-1:0];

  // Pixel consumes the current counters first; a sync edge in the same cycle applies afterwards.
  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (dv_i && in_range) x_cnt_d = x_cnt_q + X_W'(1);
    if (vs_rise) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
    end else if (hs_rise) begin
      x_cnt_d = '0;
      if (y_cnt_q != YMax) y_cnt_d = y_cnt_q + Y_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      x_cnt_q <= '0;
      y_cnt_q <= '0;
    end else begin
      hs_q    <= hs_i;
      vs_q    <= vs_i;
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
    end
  end

  // Line memories are not reset; LM0 holds the newest stored line and each write ages the column.
  always_ff @(posedge clk) begin
    if (we) begin
      lm[0][addr] <= y_i;
      for (int k = 1; k < 4; k++) lm[k][addr] <= lm[k-1][addr];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q     <= '0;
      s1_pix_q <= '0;
      s1_dv_q  <= 1'b0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
    end else begin
      if (we) begin
        for (int k = 0; k < 4; k++) rd_q[k] <= lm[k][addr];
      end
      s1_pix_q <= y_i;
      s1_dv_q  <= dv_i;
      s1_x_q   <= x_cnt_q;
      s1_y_q   <= y_cnt_q;
    end
  end

  assign col[0] = rd_q[3];
  assign col[1] = rd_q[2];
  assign col[2] = rd_q[1];
  assign col[3] = rd_q[0];
  assign col[4] = s1_pix_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_dv_q  <= 1'b0;
      s2_x_q   <= '0;
      s2_y_q   <= '0;
      win_q    <= '0;
      hs_dly_q <= '0;
      vs_dly_q <= '0;
    end else begin
      s2_dv_q  <= s1_dv_q;
      s2_x_q   <= s1_x_q;
      s2_y_q   <= s1_y_q;
      hs_dly_q <= {hs_dly_q[0], hs_i};
      vs_dly_q <= {vs_dly_q[0], vs_i};
      if (s1_dv_q) begin
        for (int r = 0; r < 5; r++) begin
          for (int c = 0; c < 4; c++) win_q[5*r+c] <= win_q[5*r+c+1];
          win_q[5*r+4] <= col[r];
        end
      end
    end
  end

  assign win_o       = win_q;
  assign x_index_o   = s2_x_q;
  assign y_index_o   = s2_y_q;
  assign win_valid_o = s2_dv_q && (s2_x_q >= X_W'(4)) && (s2_y_q >= Y_W'(4)) && (s2_x_q < XMax);
  assign dv_o        = s2_dv_q;
  assign hs_o        = hs_dly_q[1];
  assign vs_o        = vs_dly_q[1];

endmodule

// File: tb/tb_window_gen_5x5.sv
// Directed bench for window_gen_5x5 with a narrow line memory so overlong lines are cheap.
module tb_window_gen_5x5;

  localparam int unsigned DW = 8;
  localparam int unsigned MW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DW-1:0]     y_i = '0;
  logic              dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
  logic [25*DW-1:0]  win_o;
  logic              win_valid_o;
  logic [10:0]       x_index_o;
  logic [9:0]        y_index_o;
  logic              dv_o, hs_o, vs_o;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cnt = 0;

  window_gen_5x5 #(.DATA_W(DW), .MAX_WIDTH(MW), .X_W(11), .Y_W(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .y_i         (y_i),
    .dv_i        (dv_i),
    .hs_i        (hs_i),
    .vs_i        (vs_i),
    .win_o       (win_o),
    .win_valid_o (win_valid_o),
    .x_index_o   (x_index_o),
    .y_index_o   (y_index_o),
    .dv_o        (dv_o),
    .hs_o        (hs_o),
    .vs_o        (vs_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (win_valid_o) valid_cnt++;

  task automatic cyc(input logic dv, input logic [7:0] p, input logic hs, input logic vs);
    dv_i = dv; y_i = p; hs_i = hs; vs_i = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic [7:0] p, input int gap);
    cyc(1'b1, p, 1'b0, 1'b0);
    repeat (gap) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic end_line();
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic frame_start();
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [25*DW+24:0] outs;
    for (int i = 0; i < 10; i++) begin
      cyc(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      outs = {win_o, win_valid_o, x_index_o, y_index_o, dv_o, hs_o, vs_o};
      n_checks++;
      if (outs !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %0h required 0", outs);
      end
    end
    hs_i = 1'b0; vs_i = 1'b0; dv_i = 1'b1;
    valid_cnt = 0;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) send_pix(8'(c), 0);
    end_line();
    for (int l = 1; l < 4; l++) begin
      for (int c = 0; c < 6; c++) send_pix(8'(l + c), 0);
      end_line();
    end
    n_checks++;
    if (valid_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_no_valid_4_lines: got %0d required 0", valid_cnt);
    end
    for (int c = 0; c < 6; c++) send_pix(8'(c), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end_line();
    n_checks++;
    if (valid_cnt !== 2) begin
      n_fail++;
      $display("FAIL reset_line4_valid_count: got %0d required 2", valid_cnt);
    end
  endtask

  task automatic test_basic();
    logic [25*DW-1:0] ew;
    frame_start();
    valid_cnt = 0;
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < 5; c++) send_pix(8'(10 + c), 0);
      end_line();
    end
    for (int c = 0; c < 5; c++) send_pix(8'(10 + c), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) ew[DW*(5*r+c) +: DW] = 8'(10 + c);
    n_checks++;
    if (win_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_valid: got %0b required 1", win_valid_o);
    end
    n_checks++;
    if (win_o !== ew) begin
      n_fail++;
      $display("FAIL basic_window: got %0h required %0h", win_o, ew);
    end
    n_checks++;
    if ({x_index_o, y_index_o} !== {11'd4, 10'd4}) begin
      n_fail++;
      $display("FAIL basic_index: got x=%0d y=%0d required x=4 y=4", x_index_o, y_index_o);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if (win_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_valid_one_cycle: got %0b required 0", win_valid_o);
    end
    end_line();
    n_checks++;
    if (valid_cnt !== 1) begin
      n_fail++;
      $display("FAIL basic_valid_count: got %0d required 1", valid_cnt);
    end
  endtask

  task automatic test_row_order();
    logic [25*DW-1:0] ew;
    frame_start();
    valid_cnt = 0;
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 6; c++) send_pix(8'(20 * n + c), 0);
      end_line();
    end
    for (int c = 0; c < 6; c++) send_pix(8'(100 + c), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) ew[DW*(5*r+c) +: DW] = 8'(20 * (r + 1) + c + 1);
    n_checks++;
    if (win_o !== ew) begin
      n_fail++;
      $display("FAIL rows_window: got %0h required %0h", win_o, ew);
    end
    n_checks++;
    if ({win_valid_o, x_index_o, y_index_o} !== {1'b1, 11'd5, 10'd5}) begin
      n_fail++;
      $display("FAIL rows_index: got v=%0b x=%0d y=%0d required v=1 x=5 y=5",
               win_valid_o, x_index_o, y_index_o);
    end
    end_line();
    n_checks++;
    if (valid_cnt !== 4) begin
      n_fail++;
      $display("FAIL rows_valid_count: got %0d required 4", valid_cnt);
    end
  endtask

  task automatic test_frame_restart();
    logic [25*DW-1:0] ew;
    frame_start();
    valid_cnt = 0;
    for (int l = 0; l < 5; l++) begin
      for (int c = 0; c < 5; c++) send_pix(8'(10 + c), 0);
      end_line();
    end
    n_checks++;
    if (valid_cnt !== 1) begin
      n_fail++;
      $display("FAIL restart_first_frame: got %0d required 1", valid_cnt);
    end
    frame_start();
    valid_cnt = 0;
    send_pix(8'd30, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if ({x_index_o, y_index_o} !== {11'd0, 10'd0}) begin
      n_fail++;
      $display("FAIL restart_index: got x=%0d y=%0d required x=0 y=0", x_index_o, y_index_o);
    end
    for (int c = 1; c < 5; c++) send_pix(8'(30 + c), 0);
    end_line();
    for (int l = 1; l < 4; l++) begin
      for (int c = 0; c < 5; c++) send_pix(8'(30 + c), 0);
      end_line();
    end
    n_checks++;
    if (valid_cnt !== 0) begin
      n_fail++;
      $display("FAIL restart_early_valid: got %0d required 0", valid_cnt);
    end
    for (int c = 0; c < 5; c++) send_pix(8'(30 + c), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) ew[DW*(5*r+c) +: DW] = 8'(30 + c);
    n_checks++;
    if ({win_valid_o, y_index_o, win_o} !== {1'b1, 10'd4, ew}) begin
      n_fail++;
      $display("FAIL restart_line4: got v=%0b y=%0d w=%0h required v=1 y=4 w=%0h",
               win_valid_o, y_index_o, win_o, ew);
    end
    end_line();
  endtask

  task automatic test_simul_edge();
    frame_start();
    send_pix(8'd1, 0);
    end_line();
    for (int c = 0; c < 3; c++) send_pix(8'(1 + c), 0);
    cyc(1'b1, 8'h77, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if ({dv_o, x_index_o, y_index_o} !== {1'b1, 11'd3, 10'd1}) begin
      n_fail++;
      $display("FAIL simul_old_counters: got dv=%0b x=%0d y=%0d required dv=1 x=3 y=1",
               dv_o, x_index_o, y_index_o);
    end
    for (int c = 0; c < 4; c++) send_pix(8'(5 + c), 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if ({x_index_o, y_index_o} !== {11'd3, 10'd0}) begin
      n_fail++;
      $display("FAIL simul_counters_after: got x=%0d y=%0d required x=3 y=0",
               x_index_o, y_index_o);
    end
    n_checks++;
    if ({win_o[DW*19 +: DW], win_o[DW*24 +: DW]} !== {8'h77, 8'h08}) begin
      n_fail++;
      $display("FAIL simul_written_at_old_x: got %0h/%0h required 77/08",
               win_o[DW*19 +: DW], win_o[DW*24 +: DW]);
    end
    end_line();
  endtask

  task automatic test_gapped();
    logic [25*DW-1:0] ew;
    frame_start();
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 6; c++) send_pix(8'(20 * n + c), (n + c) % 3 + 1);
      end_line();
    end
    for (int c = 0; c < 5; c++) send_pix(8'(100 + c), (c == 4) ? 0 : (c % 3 + 1));
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) ew[DW*(5*r+c) +: DW] = 8'(20 * (r + 1) + c);
    n_checks++;
    if ({win_valid_o, win_o} !== {1'b1, ew}) begin
      n_fail++;
      $display("FAIL gapped_x4: got v=%0b w=%0h required v=1 w=%0h", win_valid_o, win_o, ew);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if ({win_valid_o, win_o} !== {1'b0, ew}) begin
      n_fail++;
      $display("FAIL gapped_hold: got v=%0b w=%0h required v=0 w=%0h", win_valid_o, win_o, ew);
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    send_pix(8'd105, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) ew[DW*(5*r+c) +: DW] = 8'(20 * (r + 1) + c + 1);
    n_checks++;
    if ({x_index_o, win_o} !== {11'd5, ew}) begin
      n_fail++;
      $display("FAIL gapped_x5: got x=%0d w=%0h required x=5 w=%0h", x_index_o, win_o, ew);
    end
    end_line();
  endtask

  task automatic test_overlong();
    frame_start();
    valid_cnt = 0;
    for (int l = 0; l < 5; l++) begin
      for (int c = 0; c < 10; c++) send_pix(8'(c), 0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      if (l == 4) begin
        n_checks++;
        if ({win_valid_o, x_index_o} !== {1'b0, 11'd8}) begin
          n_fail++;
          $display("FAIL overlong_saturate: got v=%0b x=%0d required v=0 x=8",
                   win_valid_o, x_index_o);
        end
      end
      end_line();
    end
    n_checks++;
    if (valid_cnt !== 4) begin
      n_fail++;
      $display("FAIL overlong_valid_count: got %0d required 4", valid_cnt);
    end
  endtask

  task automatic test_sync_delay();
    cyc(1'b1, 8'h05, 1'b1, 1'b1);
    n_checks++;
    if ({dv_o, hs_o, vs_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL sync_delay_1: got %b required 000", {dv_o, hs_o, vs_o});
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if ({dv_o, hs_o, vs_o} !== 3'b111) begin
      n_fail++;
      $display("FAIL sync_delay_2: got %b required 111", {dv_o, hs_o, vs_o});
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if ({dv_o, hs_o, vs_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL sync_delay_3: got %b required 000", {dv_o, hs_o, vs_o});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_row_order();
    test_frame_restart();
    test_simul_edge();
    test_gapped();
    test_overlong();
    test_sync_delay();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
